// File: rtl/vend_ctrl_p_if.sv
// Front-end / actuator bundle for the vending controller.
// master: coin/keypad front end and dispenser side; slave: the controller.
interface vend_ctrl_p_if #(
  parameter int unsigned NUM_ITEMS = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned PRICE_W   = 9,
  parameter int unsigned INV_W     = 4
);
  logic                         nickel;
  logic                         dime;
  logic                         quarter;
  logic                         dollar;
  logic                         pay_card;
  logic [PRICE_W-1:0]           card_balance;
  logic                         sel_valid;
  logic [IDX_W-1:0]             sel_index;
  logic                         cancel;
  logic [NUM_ITEMS*PRICE_W-1:0] price_table;
  logic                         restock;
  logic [IDX_W-1:0]             restock_index;
  logic [INV_W-1:0]             restock_count;

  logic                         vend_valid;
  logic [IDX_W-1:0]             vend_index;
  logic                         card_charge;
  logic [PRICE_W-1:0]           charge_amt;
  logic                         quarter_o;
  logic                         dime_o;
  logic                         nickel_o;
  logic                         sel_err;
  logic                         coin_reject;
  logic [PRICE_W-1:0]           credit;
  logic [NUM_ITEMS-1:0]         sold_out;
  logic                         busy;

  modport master (
    output nickel, dime, quarter, dollar, pay_card, card_balance, sel_valid, sel_index,
           cancel, price_table, restock, restock_index, restock_count,
    input  vend_valid, vend_index, card_charge, charge_amt, quarter_o, dime_o, nickel_o,
           sel_err, coin_reject, credit, sold_out, busy
  );

  modport slave (
    input  nickel, dime, quarter, dollar, pay_card, card_balance, sel_valid, sel_index,
           cancel, price_table, restock, restock_index, restock_count,
    output vend_valid, vend_index, card_charge, charge_amt, quarter_o, dime_o, nickel_o,
           sel_err, coin_reject, credit, sold_out, busy
  );
endinterface

// File: rtl/vend_ctrl_p.sv
// Vending controller: coin/card payment, per-slot price and inventory checks,
// single-cycle vend strobe and serial greedy change return.
module vend_ctrl_p #(
  parameter int unsigned NUM_ITEMS  = 8,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned PRICE_W    = 9,
  parameter int unsigned INV_W      = 4,
  parameter int unsigned INIT_INV   = 5,
  parameter int unsigned MAX_CREDIT = 500
) (
  input logic          clk,
  input logic          rst,
  vend_ctrl_p_if.slave bus
);
  // Wide enough for credit plus a full cycle of coins (up to 140).
  localparam int unsigned SumW    = ((PRICE_W > 8) ? PRICE_W : 8) + 1;
  localparam int unsigned InvSumW = INV_W + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

  state_e             state_q;
  logic [PRICE_W-1:0] credit_q;
  logic [PRICE_W-1:0] remaining_q;
  logic [PRICE_W-1:0] price_q;
  logic [IDX_W-1:0]   idx_q;
  logic               card_q;
  logic               vend_valid_q;
  logic [IDX_W-1:0]   vend_index_q;
  logic               card_charge_q;
  logic [PRICE_W-1:0] charge_amt_q;
  logic               quarter_q;
  logic               dime_q;
  logic               nickel_q;
  logic               sel_err_q;
  logic               coin_reject_q;
  logic [INV_W-1:0]   inv_q [NUM_ITEMS];

  logic [SumW-1:0]      coin_val;
  logic [SumW-1:0]      credit_sum;
  logic                 any_coin;
  logic                 coin_fits;
  logic [PRICE_W-1:0]   sel_price;
  logic                 sel_stock;
  logic [PRICE_W-1:0]   vend_rem;
  logic [InvSumW-1:0]   inv_sum [NUM_ITEMS];
  logic [INV_W-1:0]     inv_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] sold_vec;

  // Greedy change coin for an amount, as {quarter, dime, nickel}.
  function automatic logic [2:0] coin_pick(input logic [PRICE_W-1:0] amt);
    if (amt >= PRICE_W'(25))      coin_pick = 3'b100;
    else if (amt >= PRICE_W'(10)) coin_pick = 3'b010;
    else if (amt >= PRICE_W'(5))  coin_pick = 3'b001;
    else                          coin_pick = 3'b000;
  endfunction

  // Value of the coin coin_pick would emit for the same amount.
  function automatic logic [PRICE_W-1:0] coin_take(input logic [PRICE_W-1:0] amt);
    if (amt >= PRICE_W'(25))      coin_take = PRICE_W'(25);
    else if (amt >= PRICE_W'(10)) coin_take = PRICE_W'(10);
    else if (amt >= PRICE_W'(5))  coin_take = PRICE_W'(5);
    else                          coin_take = '0;
  endfunction

  // Value of this cycle's coin pulses and whether it fits under the credit ceiling.
  always_comb begin
    coin_val = '0;
    if (bus.nickel)  coin_val = coin_val + SumW'(5);
    if (bus.dime)    coin_val = coin_val + SumW'(10);
    if (bus.quarter) coin_val = coin_val + SumW'(25);
    if (bus.dollar)  coin_val = coin_val + SumW'(100);
    any_coin   = bus.nickel | bus.dime | bus.quarter | bus.dollar;
    credit_sum = SumW'(credit_q) + coin_val;
    coin_fits  = (credit_sum <= SumW'(MAX_CREDIT));
  end

  // Price and stock of the selected slot; out-of-range indices match nothing.
  always_comb begin
    sel_price = '0;
    sel_stock = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (bus.sel_index == IDX_W'(i)) begin
        sel_price = bus.price_table[i*PRICE_W +: PRICE_W];
        sel_stock = (inv_q[i] != '0);
      end
    end
  end

  assign vend_rem = credit_q - price_q;

  // Next inventory: vend decrement and restock combine, then saturate.
  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      inv_sum[i] = {1'b0, inv_q[i]};
      // A slot in VEND was accepted with stock > 0, so this cannot underflow.
      if (state_q == StVend && idx_q == IDX_W'(i)) begin
        inv_sum[i] = inv_sum[i] - InvSumW'(1);
      end
      if (bus.restock && bus.restock_index == IDX_W'(i)) begin
        inv_sum[i] = inv_sum[i] + {1'b0, bus.restock_count};
      end
      inv_d[i] = inv_sum[i][INV_W] ? '1 : inv_sum[i][INV_W-1:0];
    end
  end

  // Per-slot inventory registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) inv_q[i] <= INV_W'(INIT_INV);
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) inv_q[i] <= inv_d[i];
    end
  end

  // Sold-out flags decoded straight from inventory.
  always_comb begin
    sold_vec = '0;
    for (int i = 0; i < NUM_ITEMS; i++) sold_vec[i] = (inv_q[i] == '0);
  end

  // Transaction FSM with registered strobes; outputs set on the edge entering their cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      remaining_q   <= '0;
      price_q       <= '0;
      idx_q         <= '0;
      card_q        <= 1'b0;
      vend_valid_q  <= 1'b0;
      vend_index_q  <= '0;
      card_charge_q <= 1'b0;
      charge_amt_q  <= '0;
      quarter_q     <= 1'b0;
      dime_q        <= 1'b0;
      nickel_q      <= 1'b0;
      sel_err_q     <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      vend_valid_q                    <= 1'b0;
      vend_index_q                    <= '0;
      card_charge_q                   <= 1'b0;
      charge_amt_q                    <= '0;
      {quarter_q, dime_q, nickel_q}   <= 3'b000;
      sel_err_q                       <= 1'b0;
      coin_reject_q                   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.sel_valid && bus.pay_card && sel_stock && bus.card_balance >= sel_price) begin
            state_q       <= StVend;
            card_q        <= 1'b1;
            idx_q         <= bus.sel_index;
            price_q       <= sel_price;
            vend_valid_q  <= 1'b1;
            vend_index_q  <= bus.sel_index;
            card_charge_q <= 1'b1;
            charge_amt_q  <= sel_price;
            coin_reject_q <= any_coin;
          end else begin
            sel_err_q <= bus.sel_valid;
            if (any_coin) begin
              if (coin_fits) begin
                credit_q <= PRICE_W'(credit_sum);
                state_q  <= StCollect;
              end else begin
                coin_reject_q <= 1'b1;
              end
            end
          end
        end
        StCollect: begin
          if (bus.cancel) begin
            // First refund coin goes out on this same edge.
            state_q                       <= StChange;
            credit_q                      <= '0;
            {quarter_q, dime_q, nickel_q} <= coin_pick(credit_q);
            remaining_q                   <= credit_q - coin_take(credit_q);
            coin_reject_q                 <= any_coin;
          end else if (bus.sel_valid && sel_stock && credit_q >= sel_price) begin
            state_q       <= StVend;
            card_q        <= 1'b0;
            idx_q         <= bus.sel_index;
            price_q       <= sel_price;
            vend_valid_q  <= 1'b1;
            vend_index_q  <= bus.sel_index;
            coin_reject_q <= any_coin;
          end else begin
            sel_err_q <= bus.sel_valid;
            if (any_coin) begin
              if (coin_fits) credit_q <= PRICE_W'(credit_sum);
              else           coin_reject_q <= 1'b1;
            end
          end
        end
        StVend: begin
          coin_reject_q <= any_coin;
          credit_q      <= '0;
          if (card_q || vend_rem < PRICE_W'(5)) begin
            state_q <= StIdle;
          end else begin
            state_q                       <= StChange;
            {quarter_q, dime_q, nickel_q} <= coin_pick(vend_rem);
            remaining_q                   <= vend_rem - coin_take(vend_rem);
          end
        end
        StChange: begin
          coin_reject_q <= any_coin;
          if (remaining_q >= PRICE_W'(5)) begin
            {quarter_q, dime_q, nickel_q} <= coin_pick(remaining_q);
            remaining_q                   <= remaining_q - coin_take(remaining_q);
          end else begin
            // Sub-nickel residue is dropped.
            state_q     <= StIdle;
            remaining_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.vend_valid  = vend_valid_q;
  assign bus.vend_index  = vend_index_q;
  assign bus.card_charge = card_charge_q;
  assign bus.charge_amt  = charge_amt_q;
  assign bus.quarter_o   = quarter_q;
  assign bus.dime_o      = dime_q;
  assign bus.nickel_o    = nickel_q;
  assign bus.sel_err     = sel_err_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.credit      = credit_q;
  assign bus.sold_out    = sold_vec;
  assign bus.busy        = (state_q == StVend) || (state_q == StChange);
endmodule

// File: tb/tb_vend_ctrl_p.sv
// Scoreboard bench for vend_ctrl_p: the driver pushes expected output cycles,
// a forked monitor pops and compares whenever any strobe is seen.
module tb_vend_ctrl_p;
  localparam int unsigned NUM_ITEMS  = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned PRICE_W    = 9;
  localparam int unsigned INV_W      = 4;
  localparam int unsigned INIT_INV   = 5;
  localparam int unsigned MAX_CREDIT = 500;
  localparam int          InvMax     = 15;

  typedef struct packed {
    logic               vv;
    logic [IDX_W-1:0]   vi;
    logic               cc;
    logic [PRICE_W-1:0] ca;
    logic               q;
    logic               d;
    logic               n;
    logic               se;
    logic               cr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_ctrl_p_if #(
    .NUM_ITEMS(NUM_ITEMS), .IDX_W(IDX_W), .PRICE_W(PRICE_W), .INV_W(INV_W)
  ) bus ();

  vend_ctrl_p #(
    .NUM_ITEMS(NUM_ITEMS), .IDX_W(IDX_W), .PRICE_W(PRICE_W), .INV_W(INV_W),
    .INIT_INV(INIT_INV), .MAX_CREDIT(MAX_CREDIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int  price [NUM_ITEMS] = '{50, 85, 100, 75, 0, 35, 125, 10};
  int  m_inv [NUM_ITEMS];
  int  m_credit;
  bit  m_collect;
  ev_t exp_q[$];
  int  total;
  int  bad;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_ITEMS-1:0] m_sold();
    logic [NUM_ITEMS-1:0] s;
    for (int i = 0; i < NUM_ITEMS; i++) s[i] = (m_inv[i] == 0);
    return s;
  endfunction

  function automatic int sat_inv(input int v);
    return (v > InvMax) ? InvMax : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ITEMS; i++) m_inv[i] = INIT_INV;
    m_credit  = 0;
    m_collect = 0;
  endtask

  task automatic idle_inputs();
    bus.nickel        = 1'b0;
    bus.dime          = 1'b0;
    bus.quarter       = 1'b0;
    bus.dollar        = 1'b0;
    bus.pay_card      = 1'b0;
    bus.card_balance  = '0;
    bus.sel_valid     = 1'b0;
    bus.sel_index     = '0;
    bus.cancel        = 1'b0;
    bus.restock       = 1'b0;
    bus.restock_index = '0;
    bus.restock_count = '0;
  endtask

  // Greedy change as coin counts; cr folds into the first change cycle.
  task automatic push_change(input int amt, input bit cr);
    int  nq;
    int  nd;
    int  nn;
    ev_t e;
    nq = amt / 25;
    nd = (amt % 25) / 10;
    nn = ((amt % 25) % 10) / 5;
    for (int k = 0; k < nq + nd + nn; k++) begin
      e = '0;
      if (k < nq)           e.q = 1'b1;
      else if (k < nq + nd) e.d = 1'b1;
      else                  e.n = 1'b1;
      if (k == 0) e.cr = cr;
      exp_q.push_back(e);
    end
    if (nq + nd + nn == 0 && cr) begin
      e    = '0;
      e.cr = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // One transaction cycle; late_rs/late_coin are driven during the VEND cycle if one follows.
  task automatic step(input logic [3:0] coins, input bit sel, input int idx, input bit card,
                      input int bal, input bit cxl, input bit rs, input int rs_idx,
                      input int rs_cnt, input int late_rs, input bit late_coin);
    int  v;
    int  rem;
    int  waited;
    bit  vend;
    ev_t e;
    v    = (coins[0] ? 5 : 0) + (coins[1] ? 10 : 0) + (coins[2] ? 25 : 0) + (coins[3] ? 100 : 0);
    vend = 1'b0;
    rem  = 0;
    bus.nickel        = coins[0];
    bus.dime          = coins[1];
    bus.quarter       = coins[2];
    bus.dollar        = coins[3];
    bus.sel_valid     = sel;
    bus.sel_index     = IDX_W'(idx);
    bus.pay_card      = card;
    bus.card_balance  = PRICE_W'(bal);
    bus.cancel        = cxl;
    bus.restock       = rs;
    bus.restock_index = IDX_W'(rs_idx);
    bus.restock_count = INV_W'(rs_cnt);
    e = '0;
    if (!m_collect) begin
      if (sel && card && idx < NUM_ITEMS && m_inv[idx] > 0 && bal >= price[idx]) begin
        vend = 1'b1;
        e.vv = 1'b1;
        e.vi = IDX_W'(idx);
        e.cc = 1'b1;
        e.ca = PRICE_W'(price[idx]);
        e.cr = (v != 0);
        exp_q.push_back(e);
      end else begin
        e.se = sel;
        if (v != 0) begin
          if (v <= MAX_CREDIT) begin
            m_credit  = v;
            m_collect = 1'b1;
          end else begin
            e.cr = 1'b1;
          end
        end
        if (e.se || e.cr) exp_q.push_back(e);
      end
    end else if (cxl) begin
      push_change(m_credit, v != 0);
      m_credit  = 0;
      m_collect = 1'b0;
    end else if (sel && idx < NUM_ITEMS && m_inv[idx] > 0 && m_credit >= price[idx]) begin
      vend = 1'b1;
      e.vv = 1'b1;
      e.vi = IDX_W'(idx);
      e.cr = (v != 0);
      exp_q.push_back(e);
      rem       = m_credit - price[idx];
      m_credit  = 0;
      m_collect = 1'b0;
    end else begin
      e.se = sel;
      if (v != 0) begin
        if (m_credit + v <= MAX_CREDIT) m_credit = m_credit + v;
        else                            e.cr = 1'b1;
      end
      if (e.se || e.cr) exp_q.push_back(e);
    end
    if (vend) push_change(rem, late_coin);
    if (rs && rs_idx < NUM_ITEMS) m_inv[rs_idx] = sat_inv(m_inv[rs_idx] + rs_cnt);
    if (vend) m_inv[idx] = sat_inv(m_inv[idx] - 1 + late_rs);

    @(negedge clk);
    idle_inputs();
    if (vend && (late_rs > 0 || late_coin)) begin
      bus.restock       = (late_rs > 0);
      bus.restock_index = IDX_W'(idx);
      bus.restock_count = INV_W'(late_rs);
      bus.dime          = late_coin;
      @(negedge clk);
      idle_inputs();
    end
    waited = 0;
    while (bus.busy && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("busy_timeout", bus.busy, 0);
    check("credit", bus.credit, m_credit);
    check("sold_out", bus.sold_out, m_sold());
  endtask

  task automatic put_coins(input logic [3:0] c);
    step(c, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pick(input int idx);
    step(4'b0000, 1, idx, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pick_card(input int idx, input int bal);
    step(4'b0000, 1, idx, 1, bal, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_cancel();
    step(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ev_t         act;
    ev_t         e;
    logic [3:0]  coins;
    bit          sel;
    bit          card;
    bit          cxl;
    bit          rs;
    int          idx;
    int          bal;
    int          r;
    total = 0;
    bad   = 0;
    model_reset();
    idle_inputs();
    for (int i = 0; i < NUM_ITEMS; i++) bus.price_table[i*PRICE_W +: PRICE_W] = PRICE_W'(price[i]);

    fork
      forever begin
        @(negedge clk);
        if (rst && (bus.vend_valid || bus.card_charge || bus.quarter_o || bus.dime_o ||
                    bus.nickel_o || bus.sel_err || bus.coin_reject)) begin
          act    = '0;
          act.vv = bus.vend_valid;
          act.vi = bus.vend_valid ? bus.vend_index : '0;
          act.cc = bus.card_charge;
          act.ca = bus.card_charge ? bus.charge_amt : '0;
          act.q  = bus.quarter_o;
          act.d  = bus.dime_o;
          act.n  = bus.nickel_o;
          act.se = bus.sel_err;
          act.cr = bus.coin_reject;
          if (exp_q.size() == 0) begin
            check("unexpected_output", act, 0);
          end else begin
            e = exp_q.pop_front();
            check("output_event", act, e);
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_strobes", {bus.vend_valid, bus.card_charge, bus.quarter_o, bus.dime_o,
                            bus.nickel_o, bus.sel_err, bus.coin_reject, bus.busy}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_credit", bus.credit, 0);
    check("reset_sold_out", bus.sold_out, 0);

    // Exact change, change with a coin during VEND, non-card idle select.
    put_coins(4'b1000);
    pick(2);
    put_coins(4'b1000);
    put_coins(4'b0100);
    pick(1);
    put_coins(4'b1000);
    step(4'b0000, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    pick(3);

    // Credit ceiling then cancel.
    repeat (5) put_coins(4'b1000);
    put_coins(4'b1000);
    do_cancel();

    // Card path.
    pick_card(3, 60);
    pick_card(3, 80);
    step(4'b0000, 1, 2, 1, 100, 0, 0, 0, 0, 0, 1);

    // Price zero returns all credit.
    put_coins(4'b0110);
    pick(4);

    // Drain slot 0, sold-out reject, restock coinciding with VEND.
    repeat (5) begin
      put_coins(4'b1000);
      pick(0);
    end
    check("slot0_sold_out", bus.sold_out[0], 1);
    repeat (5) put_coins(4'b1000);
    pick(0);
    do_cancel();
    step(4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    put_coins(4'b1000);
    step(4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    repeat (3) begin
      put_coins(4'b1000);
      pick(0);
    end

    // Saturating restock: 5 + 15 + 15 caps at 15.
    step(4'b0000, 0, 0, 0, 0, 0, 1, 7, 15, 0, 0);
    step(4'b0000, 0, 0, 0, 0, 0, 1, 7, 15, 0, 0);
    repeat (16) begin
      put_coins(4'b0010);
      pick(7);
    end
    do_cancel();

    // Cancel, select and a coin in the same COLLECT cycle.
    put_coins(4'b0100);
    step(4'b0010, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int it = 0; it < 300; it++) begin
      r     = int'($urandom_range(0, 9));
      coins = 4'b0000;
      sel   = 1'b0;
      card  = ($urandom_range(0, 3) != 0);
      cxl   = 1'b0;
      idx   = int'($urandom_range(0, NUM_ITEMS - 1));
      bal   = int'($urandom_range(0, 150));
      rs    = ($urandom_range(0, 5) == 0);
      if (r < 4) begin
        coins = 4'($urandom_range(1, 15));
      end else if (r < 8) begin
        sel = 1'b1;
        if (m_collect && $urandom_range(0, 3) == 0) coins = 4'($urandom_range(1, 15));
      end else begin
        cxl = 1'b1;
        if ($urandom_range(0, 1) == 1) coins = 4'($urandom_range(1, 15));
      end
      step(coins, sel, idx, card, bal, cxl, rs, int'($urandom_range(0, NUM_ITEMS - 1)),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : 0,
           ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a refund.
    if (m_collect) do_cancel();
    put_coins(4'b1000);
    bus.cancel = 1'b1;
    push_change(m_credit, 0);
    @(negedge clk);
    bus.cancel = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs", {bus.vend_valid, bus.card_charge, bus.quarter_o, bus.dime_o,
                                  bus.nickel_o, bus.sel_err, bus.coin_reject, bus.busy}, 0);
    check("async_reset_credit", bus.credit, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_sold_out", bus.sold_out, 0);
    put_coins(4'b1000);
    pick(2);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vend_ctrl_p.md
# vend_ctrl_p

Parametrised vending controller. It accepts coin and card payment, checks each selection against a per-slot price table and a per-slot inventory, and issues a single-cycle vend strobe. Change is returned serially, one coin per cycle, using greedy quarter/dime/nickel decomposition. The block sits between the coin/keypad front end and the dispenser and coin-return actuators, and it supports any number of items and any price width.

## Interface
Parameters:
- NUM_ITEMS, 8, number of product slots
- IDX_W, 3, selection index width; must satisfy 2^IDX_W ≥ NUM_ITEMS
- PRICE_W, 9, width of price, credit and balance values (cents)
- INV_W, 4, per-slot inventory counter width
- INIT_INV, 5, inventory loaded into every slot at reset
- MAX_CREDIT, 500, ceiling on accumulated coin credit; must be ≤ 2^PRICE_W−1

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- nickel, dime, quarter, dollar  in  1 each  single-cycle coin pulses worth 5/10/25/100
- pay_card  in  1  card mode; sampled with sel_valid
- card_balance  in  PRICE_W  available card funds; sampled with sel_valid
- sel_valid  in  1  selection strobe
- sel_index  in  IDX_W  selected slot
- cancel  in  1  abort the transaction and return the credit
- price_table  in  NUM_ITEMS*PRICE_W  slot i price at bits [i*PRICE_W +: PRICE_W]
- restock  in  1  restock strobe
- restock_index  in  IDX_W  slot to restock
- restock_count  in  INV_W  units to add
- vend_valid  out  1  one-cycle dispense strobe
- vend_index  out  IDX_W  slot dispensed; valid with vend_valid
- card_charge  out  1  one-cycle card debit strobe
- charge_amt  out  PRICE_W  debit amount; valid with card_charge
- quarter_o, dime_o, nickel_o  out  1 each  one-cycle coin-return pulses; at most one high per cycle
- sel_err  out  1  one-cycle strobe: selection rejected
- coin_reject  out  1  one-cycle strobe: a coin was not credited
- credit  out  PRICE_W  current coin credit
- sold_out  out  NUM_ITEMS  bit i high when slot i inventory is 0
- busy  out  1  high in VEND or CHANGE

## Operation
States: IDLE, COLLECT, VEND, CHANGE.

Coin value for a cycle is the sum of all coin pulses asserted in that cycle.

- **IDLE**
  - Coin pulses load credit and move to COLLECT.
  - sel_valid with pay_card=1 is accepted if the slot is not sold out and card_balance ≥ price. The card path then goes to VEND.
  - Any other selection pulses sel_err and stays in IDLE.
  - cancel is ignored.
- **COLLECT**
  - Priority order: cancel, then sel_valid, then coins.
  - cancel: move to CHANGE with the remaining balance equal to credit.
  - sel_valid is accepted if inventory > 0 and credit ≥ price (pay_card is ignored here). Accepted selections go to VEND; rejected ones pulse sel_err and stay in COLLECT.
  - Coins in the same cycle as cancel or an accepted selection are rejected.
  - Otherwise coins are added to credit. If credit + coins > MAX_CREDIT, the whole cycle's coins are rejected: coin_reject pulses and credit is unchanged.
- **VEND** (one cycle)
  - vend_valid=1, vend_index = latched index, and the slot inventory decrements.
  - Coin path: remaining = credit − price, and credit becomes 0. Go to CHANGE if remaining ≥ 5, else IDLE.
  - Card path: card_charge=1 and charge_amt = price, then go to IDLE.
- **CHANGE**
  - Each cycle emits one coin: quarter_o if remaining ≥ 25, else dime_o if ≥ 10, else nickel_o if ≥ 5. The coin's value is subtracted from remaining.
  - Go to IDLE in the cycle remaining drops below 5. Any residual < 5 is discarded.
- **In VEND and CHANGE:** coins pulse coin_reject, and sel_valid/cancel are ignored with no sel_err.
- **Restock** is honoured in every state. It adds restock_count to the slot and saturates at 2^INV_W−1.
  - If it coincides with a VEND decrement of the same slot, the result is sat(inv − 1 + count).
  - Indices ≥ NUM_ITEMS are ignored.
- **Selection range:** sel_index ≥ NUM_ITEMS is rejected with sel_err.
- **Price 0** is a legal price: the selection is accepted and the full credit is returned as change.

## Timing
- **Reset values:** state IDLE, credit 0, every inventory slot = INIT_INV, and all strobe and coin outputs 0.
  - sold_out is all-zero if INIT_INV > 0.
  - Reset asserted mid-transaction aborts it with no change returned.
- **Output timing:** all outputs are registered, except sold_out, which is decoded from the inventory registers.
- **Latencies:** a selection accepted at edge N gives vend_valid high for cycle N+1, and the first change coin in cycle N+2. A cancel at edge N gives the first coin in cycle N+1.
- **Credit visibility:** a coin pulse at edge N appears on credit in cycle N+1.
- **Change duration:** returning change takes one cycle per coin. The maximum is ⌈MAX_CREDIT/25⌉ + 2 cycles.

## Test plan
- **Exact-change coin sale:** reset; dollar pulse; select slot 2 (price 100). Expect vend_valid with vend_index=2 one cycle later, no coin pulses, return to IDLE, and slot 2 inventory 5→4.
- **Coin sale with change:** dollar then quarter (credit 125); select a price of 85. Expect vend_valid, then quarter_o, dime_o, nickel_o on consecutive cycles, then IDLE with credit 0.
- **Credit ceiling and cancel:** MAX_CREDIT=500; five dollars, then a sixth. Expect coin_reject and credit held at 500. Then cancel: expect 20 quarter_o pulses, then IDLE.
- **Card path:** pay_card=1, card_balance=60, select a price of 75: expect sel_err. Then card_balance=80, same selection: expect vend_valid plus card_charge with charge_amt=75, and no coin pulses.
- **Sold out and restock:** drain slot 0 to 0 and check sold_out[0]=1; select slot 0 with credit 500: expect sel_err. Restock slot 0 by 3 in the same cycle as a VEND of slot 0 at inventory 1: expect 3. Restock past 15 saturates at 15.
- **Simultaneous events and reset:** cancel, sel_valid and a dime in the same COLLECT cycle: expect CHANGE, coin_reject, and no vend. Drop rst mid-CHANGE: expect all outputs 0 and IDLE immediately (asynchronous).
